// File: rtl/fp_mul_arb_pkg.sv
// fp_mul_arb_pkg: state type, widths and rounding-mode constants shared by fp_mul_arbiter
package fp_mul_arb_pkg;
  localparam int FP_W = 32;
  localparam int RM_W = 3;
  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} arb_state_t;
  function automatic logic [RM_W-1:0] legal_rm(input logic [RM_W-1:0] rm);
    return (rm > RM_RMM) ? RM_RNE : rm;
  endfunction
endpackage

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [IW:0] w_j;
  // Walk offsets high to low so the closest request to the pointer wins last
  always_comb begin
    o_idx = i_ptr;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = {1'b0, i_ptr} + (IW+1)'(k);
      w_j = (w_j >= (IW+1)'(N)) ? w_j - (IW+1)'(N) : w_j;
      if (i_req[w_j[IW-1:0]]) o_idx = w_j[IW-1:0];
    end
  end
  assign o_gnt = (|i_req) ? {{(N-1){1'b0}}, 1'b1} << o_idx : '0;
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sequencer sharing one combinational FP multiplier among NUM_REQ lanes.
// Define FP_MUL_ARB_FFLAGS_EN to add sticky overflow/underflow flags with a clear input.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_x,
  input  logic [NUM_REQ*FP_W-1:0] req_y,
  input  logic [NUM_REQ*RM_W-1:0] req_rmode,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [FP_W-1:0]         resp_z,
  output logic                    resp_ovrf,
  output logic                    resp_udrf,
  output logic [FP_W-1:0]         mul_x,
  output logic [FP_W-1:0]         mul_y,
  output logic [RM_W-1:0]         mul_rmode,
  input  logic [FP_W-1:0]         mul_z,
  input  logic                    mul_ovrf,
  input  logic                    mul_udrf
`ifdef FP_MUL_ARB_FFLAGS_EN
  ,
  input  logic                    fflags_clr,
  output logic                    fflags_ovrf,
  output logic                    fflags_udrf
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_gnt, w_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [FP_W-1:0] r_x, r_y, r_z;
  logic [RM_W-1:0] r_rm;
  logic r_ovrf, r_udrf, w_req_hs, w_resp_hs;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req(req_valid),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx)
  );
  assign w_req_hs   = (r_state == IDLE) && (|req_valid);
  assign w_resp_hs  = (r_state == DONE) && resp_ready[r_gnt];
  assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
  assign resp_valid = (r_state == DONE) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gnt : '0;
  assign resp_z     = r_z;
  assign resp_ovrf  = r_ovrf;
  assign resp_udrf  = r_udrf;
  assign mul_x      = r_x;
  assign mul_y      = r_y;
  assign mul_rmode  = r_rm;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_req_hs ? EXEC : IDLE;
      EXEC:    w_next = DONE;
      DONE:    w_next = w_resp_hs ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_rm   <= RM_RNE;
      r_z    <= '0;
      r_ovrf <= 1'b0;
      r_udrf <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_x   <= req_x[w_idx*FP_W +: FP_W];
        r_y   <= req_y[w_idx*FP_W +: FP_W];
        r_rm  <= legal_rm(req_rmode[w_idx*RM_W +: RM_W]);
        r_gnt <= w_idx;
        r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == EXEC) begin
        r_z    <= mul_z;
        r_ovrf <= mul_ovrf;
        r_udrf <= mul_udrf;
      end
    end
  end
`ifdef FP_MUL_ARB_FFLAGS_EN
  logic r_ff_ovrf, r_ff_udrf;
  // A capture in the same cycle as a clear is still recorded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff_ovrf <= 1'b0;
      r_ff_udrf <= 1'b0;
    end else begin
      r_ff_ovrf <= (r_ff_ovrf & ~fflags_clr) | ((r_state == EXEC) & mul_ovrf);
      r_ff_udrf <= (r_ff_udrf & ~fflags_clr) | ((r_state == EXEC) & mul_udrf);
    end
  end
  assign fflags_ovrf = r_ff_ovrf;
  assign fflags_udrf = r_ff_udrf;
`endif
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed self-checking bench for fp_mul_arbiter with a table-driven core model
module tb_fp_mul_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = '0, resp_ready = '0;
  logic [1:0] req_ready, resp_valid;
  logic [63:0] req_x = '0, req_y = '0;
  logic [5:0] req_rmode = '0;
  logic [31:0] resp_z, mul_x, mul_y, mul_z;
  logic resp_ovrf, resp_udrf, mul_ovrf, mul_udrf;
  logic [2:0] mul_rmode;
  logic [1:0] g;
  int n_chk = 0, n_err = 0;
`ifdef FP_MUL_ARB_FFLAGS_EN
  logic fflags_clr = 1'b0;
  logic fflags_ovrf, fflags_udrf;
`endif
  always #5 clk = ~clk;
  // Known products for the directed operands; anything else returns a mix that exposes rmode
  function automatic logic [33:0] core(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    if (x == 32'h40400000 && y == 32'h40400000) return {2'b00, 32'h41100000};
    if (x == 32'h40000000 && y == 32'h40000000) return {2'b00, 32'h40800000};
    if (x == 32'h7F000000 && y == 32'h7F000000) return {2'b10, 32'h7F800000};
    if (x == 32'h00800000 && y == 32'h00800000) return {2'b01, 32'h00000000};
    return {2'b00, x ^ y ^ {29'b0, rm}};
  endfunction
  assign {mul_ovrf, mul_udrf, mul_z} = core(mul_x, mul_y, mul_rmode);
  fp_mul_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_z(resp_z), .resp_ovrf(resp_ovrf), .resp_udrf(resp_udrf),
    .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode),
    .mul_z(mul_z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf)
`ifdef FP_MUL_ARB_FFLAGS_EN
    , .fflags_clr(fflags_clr), .fflags_ovrf(fflags_ovrf), .fflags_udrf(fflags_udrf)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_z", resp_z, 32'h0);
    chk("rst_flags", {30'b0, resp_ovrf, resp_udrf}, 32'h0);
    chk("rst_mul_x", mul_x, 32'h0);
    chk("rst_mul_rmode", 32'(mul_rmode), 32'h0);
    rst = 1'b0;
    // single request from lane 0: 3.0 * 3.0, RTZ
    req_x[31:0] = 32'h40400000;
    req_y[31:0] = 32'h40400000;
    req_rmode[2:0] = 3'b001;
    req_valid = 2'b01;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("exec_mul_x", mul_x, 32'h40400000);
    chk("exec_mul_y", mul_y, 32'h40400000);
    chk("exec_mul_rmode", 32'(mul_rmode), 32'h1);
    chk("exec_resp_valid", 32'(resp_valid), 32'h0);
    tick();
    chk("done_resp_valid", 32'(resp_valid), 32'h1);
    chk("done_resp_z", resp_z, 32'h41100000);
    chk("done_flags", {30'b0, resp_ovrf, resp_udrf}, 32'h0);
    // backpressure while both lanes are requesting
    req_x[63:32] = 32'h40000000;
    req_y[63:32] = 32'h40000000;
    req_rmode[5:3] = 3'b000;
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_resp_valid", 32'(resp_valid), 32'h1);
      chk("bp_resp_z", resp_z, 32'h41100000);
      chk("bp_flags", {30'b0, resp_ovrf, resp_udrf}, 32'h0);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 2'b11;
    tick();
    chk("after_hs_ready", 32'(req_ready), 32'h2);
    // fairness: pointer now at lane 1, grants must alternate
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 0) ? 2'b10 : 2'b01;
      chk("fair_grant", 32'(req_ready), 32'(g));
      tick();
      chk("fair_exec_ready", 32'(req_ready), 32'h0);
      tick();
      chk("fair_done_ready", 32'(req_ready), 32'h0);
      chk("fair_resp_valid", 32'(resp_valid), 32'(g));
      chk("fair_resp_z", resp_z, (g == 2'b01) ? 32'h41100000 : 32'h40800000);
      tick();
    end
    req_valid = 2'b00;
    resp_ready = 2'b00;
    // illegal rounding mode, then reset while in EXEC
    req_x[31:0] = 32'h11111111;
    req_y[31:0] = 32'h00000000;
    req_rmode[2:0] = 3'b111;
    req_valid = 2'b01;
    #1;
    chk("rexec_req_ready", 32'(req_ready), 32'h1);
    tick();
    chk("illegal_rm_coerced", 32'(mul_rmode), 32'h0);
    chk("rexec_mul_x", mul_x, 32'h11111111);
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    chk("rexec_resp_valid", 32'(resp_valid), 32'h0);
    chk("rexec_ptr_zero", 32'(req_ready), 32'h1);
    chk("rexec_mul_x_clr", mul_x, 32'h0);
    rst = 1'b0;
    req_valid = 2'b00;
    tick();
    chk("rexec_no_stale", 32'(resp_valid), 32'h0);
    // underflow with rmode 101 coerced to RNE
    req_x[31:0] = 32'h00800000;
    req_y[31:0] = 32'h00800000;
    req_rmode[2:0] = 3'b101;
    req_valid = 2'b01;
    #1;
    chk("udrf_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("udrf_rm_coerced", 32'(mul_rmode), 32'h0);
    tick();
    chk("udrf_resp_valid", 32'(resp_valid), 32'h1);
    chk("udrf_resp_z", resp_z, 32'h0);
    chk("udrf_flags", {30'b0, resp_ovrf, resp_udrf}, 32'h1);
`ifdef FP_MUL_ARB_FFLAGS_EN
    chk("ff_udrf_set", 32'(fflags_udrf), 32'h1);
`endif
    resp_ready = 2'b10;
    tick();
    chk("other_ready_ignored", 32'(resp_valid), 32'h1);
    resp_ready = 2'b01;
    tick();
    chk("udrf_released", 32'(resp_valid), 32'h0);
    resp_ready = 2'b00;
    // overflow on lane 1 with legal rmode RMM
    req_x[63:32] = 32'h7F000000;
    req_y[63:32] = 32'h7F000000;
    req_rmode[5:3] = 3'b100;
    req_valid = 2'b10;
    #1;
    chk("ovrf_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    #1;
    chk("ovrf_rm_rmm", 32'(mul_rmode), 32'h4);
    tick();
    chk("ovrf_resp_valid", 32'(resp_valid), 32'h2);
    chk("ovrf_resp_z", resp_z, 32'h7F800000);
    chk("ovrf_flags", {30'b0, resp_ovrf, resp_udrf}, 32'h2);
`ifdef FP_MUL_ARB_FFLAGS_EN
    chk("ff_ovrf_set", 32'(fflags_ovrf), 32'h1);
    chk("ff_udrf_sticky", 32'(fflags_udrf), 32'h1);
`endif
    resp_ready = 2'b10;
    tick();
    chk("ovrf_released", 32'(resp_valid), 32'h0);
`ifdef FP_MUL_ARB_FFLAGS_EN
    // clear coinciding with a new overflow capture keeps the flag set
    req_valid = 2'b10;
    #1;
    chk("ff_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    #1;
    chk("ff_ovrf_set_wins", 32'(fflags_ovrf), 32'h1);
    chk("ff_udrf_cleared", 32'(fflags_udrf), 32'h0);
    tick();
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    #1;
    chk("ff_ovrf_cleared", 32'(fflags_ovrf), 32'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
